// File: rtl/a23_wb_arbiter.sv
// a23_wb_arbiter: two-master, one-slave Wishbone classic arbiter.
// Master 0 is the a23 core, master 1 is the boot/test loader. Round-robin grant,
// grant held for a whole CYC, and a watchdog that answers ERR for a silent slave.
module a23_wb_arbiter #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [AW-1:0]   i_m0_adr,
  input  logic [DW-1:0]   i_m0_dat,
  input  logic [DW/8-1:0] i_m0_sel,
  input  logic            i_m0_we,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  output logic [DW-1:0]   o_m0_dat,
  output logic            o_m0_ack,
  output logic            o_m0_err,
  input  logic [AW-1:0]   i_m1_adr,
  input  logic [DW-1:0]   i_m1_dat,
  input  logic [DW/8-1:0] i_m1_sel,
  input  logic            i_m1_we,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  output logic [DW-1:0]   o_m1_dat,
  output logic            o_m1_ack,
  output logic            o_m1_err,
  output logic [AW-1:0]   o_s_adr,
  output logic [DW-1:0]   o_s_dat,
  output logic [DW/8-1:0] o_s_sel,
  output logic            o_s_we,
  output logic            o_s_cyc,
  output logic            o_s_stb,
  input  logic [DW-1:0]   i_s_dat,
  input  logic            i_s_ack,
  input  logic            i_s_err,
  output logic [1:0]      o_grant
);

  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  // Encodings double as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_e;

  state_e        state_r, state_s;
  logic          last_r, last_s;     // master served most recently
  logic [WW-1:0] wdog_r, wdog_s;
  logic          stb_s;              // strobe of the granted master, before timeout masking
  logic          timeout_s;

  // State, round-robin history and watchdog registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      wdog_r  <= {WW{1'b0}};
    end else begin
      state_r <= state_s;
      last_r  <= last_s;
      wdog_r  <= wdog_s;
    end
  end

  // Granted strobe and watchdog expiry; a slave response in the same cycle wins.
  always_comb begin
    stb_s = 1'b0;
    case (state_r)
      GNT0:    stb_s = i_m0_stb;
      GNT1:    stb_s = i_m1_stb;
      default: stb_s = 1'b0;
    endcase
    timeout_s = stb_s & ~i_s_ack & ~i_s_err & (wdog_r == WDOG_LAST);
  end

  // Next state, round-robin history and watchdog count.
  always_comb begin
    state_s = state_r;
    last_s  = last_r;
    wdog_s  = {WW{1'b0}};
    case (state_r)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          state_s = last_r ? GNT0 : GNT1;
        end else if (i_m0_cyc) begin
          state_s = GNT0;
        end else if (i_m1_cyc) begin
          state_s = GNT1;
        end else begin
          state_s = IDLE;
        end
      end
      GNT0: begin
        if (!i_m0_cyc) begin
          state_s = IDLE;
          last_s  = 1'b0;
        end else if (stb_s && !i_s_ack && !i_s_err && !timeout_s) begin
          wdog_s = wdog_r + WW'(1);
        end else begin
          wdog_s = {WW{1'b0}};
        end
      end
      GNT1: begin
        if (!i_m1_cyc) begin
          state_s = IDLE;
          last_s  = 1'b1;
        end else if (stb_s && !i_s_ack && !i_s_err && !timeout_s) begin
          wdog_s = wdog_r + WW'(1);
        end else begin
          wdog_s = {WW{1'b0}};
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Bus routing: slave sees the granted master, responses go only to that master.
  always_comb begin
    o_grant  = 2'b00;
    o_s_adr  = {AW{1'b0}};
    o_s_dat  = {DW{1'b0}};
    o_s_sel  = {(DW/8){1'b0}};
    o_s_we   = 1'b0;
    o_s_cyc  = 1'b0;
    o_s_stb  = stb_s & ~timeout_s;
    o_m0_dat = {DW{1'b0}};
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_dat = {DW{1'b0}};
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    case (state_r)
      GNT0: begin
        o_grant  = 2'b01;
        o_s_adr  = i_m0_adr;
        o_s_dat  = i_m0_dat;
        o_s_sel  = i_m0_sel;
        o_s_we   = i_m0_we;
        o_s_cyc  = i_m0_cyc;
        o_m0_dat = i_s_dat;
        o_m0_ack = i_s_ack;
        o_m0_err = i_s_err | timeout_s;
      end
      GNT1: begin
        o_grant  = 2'b10;
        o_s_adr  = i_m1_adr;
        o_s_dat  = i_m1_dat;
        o_s_sel  = i_m1_sel;
        o_s_we   = i_m1_we;
        o_s_cyc  = i_m1_cyc;
        o_m1_dat = i_s_dat;
        o_m1_ack = i_s_ack;
        o_m1_err = i_s_err | timeout_s;
      end
      default: begin
        o_grant = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_a23_wb_arbiter.sv
// Directed self-checking bench for a23_wb_arbiter (TIMEOUT = 16).
module tb_a23_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_m0_adr, i_m0_dat, i_m1_adr, i_m1_dat, i_s_dat;
  logic [3:0]  i_m0_sel, i_m1_sel;
  logic        i_m0_we, i_m0_cyc, i_m0_stb, i_m1_we, i_m1_cyc, i_m1_stb;
  logic        i_s_ack, i_s_err;
  logic [31:0] o_m0_dat, o_m1_dat, o_s_adr, o_s_dat;
  logic [3:0]  o_s_sel;
  logic        o_m0_ack, o_m0_err, o_m1_ack, o_m1_err, o_s_we, o_s_cyc, o_s_stb;
  logic [1:0]  o_grant;

  int checks_r = 0;
  int errors_r = 0;

  a23_wb_arbiter #(.DW(32), .AW(32), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .i_m0_sel(i_m0_sel), .i_m0_we(i_m0_we),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .i_m1_sel(i_m1_sel), .i_m1_we(i_m1_we),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel), .o_s_we(o_s_we),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
    .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .i_s_err(i_s_err),
    .o_grant(o_grant)
  );

  // 100 MHz-style free-running clock.
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for any grant; returns 0 if none appears.
  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (o_grant != 2'b00) begin
        g = o_grant;
        break;
      end
    end
  endtask

  task automatic m0_req(input logic on, input logic [31:0] adr);
    i_m0_cyc = on; i_m0_stb = on; i_m0_adr = adr;
  endtask

  task automatic m1_req(input logic on, input logic [31:0] adr);
    i_m1_cyc = on; i_m1_stb = on; i_m1_adr = adr;
  endtask

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

  logic [1:0] g_s;
  logic [1:0] exp_g_s;

  // Directed test sequence.
  initial begin
    i_rst = 1'b1;
    i_m0_adr = 32'h0; i_m0_dat = 32'h0; i_m0_sel = 4'hF; i_m0_we = 1'b0;
    i_m0_cyc = 1'b0; i_m0_stb = 1'b0;
    i_m1_adr = 32'h0; i_m1_dat = 32'h0; i_m1_sel = 4'hF; i_m1_we = 1'b0;
    i_m1_cyc = 1'b0; i_m1_stb = 1'b0;
    i_s_dat = 32'hDEAD_BEEF; i_s_ack = 1'b0; i_s_err = 1'b0;

    // 1. reset state, then m0 read @0x100 acked on 2nd stb cycle
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    check("rst_grant", 64'(o_grant), 64'h0);
    check("rst_s_cyc_stb", 64'({o_s_cyc, o_s_stb}), 64'h0);
    check("rst_s_adr", 64'(o_s_adr), 64'h0);
    check("rst_m_dat", 64'({o_m0_dat, o_m1_dat}), 64'h0);
    check("rst_ack_err", 64'({o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}), 64'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_s_ack = 1'b1; i_s_err = 1'b1;
    @(negedge i_clk);
    check("idle_resp_dropped", 64'({o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}), 64'h0);
    @(posedge i_clk); #1;
    i_s_ack = 1'b0; i_s_err = 1'b0;
    m0_req(1'b1, 32'h100);
    @(negedge i_clk);
    check("arb_cycle_grant", 64'({o_grant, o_s_cyc}), 64'h0);
    @(negedge i_clk);
    check("t1_grant", 64'(o_grant), 64'h1);
    check("t1_s_adr", 64'(o_s_adr), 64'h100);
    check("t1_stb_noack", 64'({o_s_stb, o_m0_ack}), 64'h2);
    @(posedge i_clk); #1;
    i_s_ack = 1'b1; i_s_dat = 32'h0000_0005;
    @(negedge i_clk);
    check("t1_m0_ack_dat", 64'({o_m0_ack, o_m0_dat}), {31'h0, 1'b1, 32'h5});
    check("t1_m1_quiet", 64'({o_m1_ack, o_m1_dat}), 64'h0);
    @(posedge i_clk); #1;
    i_s_ack = 1'b0; i_s_dat = 32'hDEAD_BEEF;
    m0_req(1'b0, 32'h100);
    @(negedge i_clk);
    check("t1_cyc_drop", 64'({o_grant, o_s_cyc}), 64'h2);
    @(negedge i_clk);
    check("t1_idle_after", 64'(o_grant), 64'h0);

    // 2. simultaneous request after reset: m0 first, IDLE gap, then m1
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    m0_req(1'b1, 32'h200);
    m1_req(1'b1, 32'h300);
    @(negedge i_clk);
    check("t2_arb", 64'(o_grant), 64'h0);
    @(negedge i_clk);
    check("t2_first", 64'({o_grant, o_s_adr}), {30'h0, 2'b01, 32'h200});
    @(posedge i_clk); #1;
    i_s_ack = 1'b1;
    @(negedge i_clk);
    check("t2_ack_route", 64'({o_m0_ack, o_m1_ack}), 64'h2);
    @(posedge i_clk); #1;
    i_s_ack = 1'b0;
    m0_req(1'b0, 32'h200);
    @(negedge i_clk);
    @(negedge i_clk);
    check("t2_idle_gap", 64'(o_grant), 64'h0);
    @(negedge i_clk);
    check("t2_second", 64'({o_grant, o_s_adr}), {30'h0, 2'b10, 32'h300});
    @(posedge i_clk); #1;
    i_s_ack = 1'b1; i_s_err = 1'b1;
    @(negedge i_clk);
    check("t2_ack_err_both", 64'({o_m1_ack, o_m1_err, o_m0_ack, o_m0_err}), 64'hC);
    @(posedge i_clk); #1;
    i_s_ack = 1'b0; i_s_err = 1'b0;
    m1_req(1'b0, 32'h300);
    @(negedge i_clk);
    @(negedge i_clk);
    check("t2_idle_end", 64'(o_grant), 64'h0);

    // 3. both requesting back-to-back: 0,1,0,1
    @(posedge i_clk); #1;
    m0_req(1'b1, 32'h400);
    m1_req(1'b1, 32'h500);
    exp_g_s = 2'b01;
    for (int k = 0; k < 4; k++) begin
      wait_grant(g_s);
      check("t3_rr_grant", 64'(g_s), 64'(exp_g_s));
      @(posedge i_clk); #1;
      i_s_ack = 1'b1;
      @(negedge i_clk);
      check("t3_rr_ack", 64'({o_m1_ack, o_m0_ack}), 64'(exp_g_s));
      @(posedge i_clk); #1;
      i_s_ack = 1'b0;
      if (k == 3) begin
        m0_req(1'b0, 32'h400);
        m1_req(1'b0, 32'h500);
      end else if (g_s == 2'b01) begin
        m0_req(1'b0, 32'h400);
      end else begin
        m1_req(1'b0, 32'h500);
      end
      @(posedge i_clk); #1;
      if (k != 3) begin
        m0_req(1'b1, 32'h400);
        m1_req(1'b1, 32'h500);
      end
      exp_g_s = {exp_g_s[0], exp_g_s[1]};
    end

    // 4. m1 write to a silent slave: forced err on the 16th stb cycle
    i_m1_we = 1'b1; i_m1_dat = 32'hF080_0003;
    m1_req(1'b1, 32'h0);
    @(posedge i_clk);
    for (int n = 1; n <= 17; n++) begin
      @(negedge i_clk);
      if (n == 1) begin
        check("t4_s_wr", 64'({o_s_we, o_s_dat}), {31'h0, 1'b1, 32'hF080_0003});
      end
      check("t4_wdog", 64'({o_m1_err, o_s_stb, o_m0_err, o_m0_ack, o_m1_ack}),
            (n == 16) ? 64'h10 : 64'h08);
      if (n == 16) begin
        check("t4_m0_dat", 64'(o_m0_dat), 64'h0);
      end
    end
    @(posedge i_clk); #1;
    m1_req(1'b0, 32'h0);
    i_m1_we = 1'b0;
    @(posedge i_clk); #1;

    // 5. ack coinciding with watchdog expiry wins, watchdog restarts from 0
    m0_req(1'b1, 32'h600);
    @(posedge i_clk);
    repeat (15) @(negedge i_clk);
    @(posedge i_clk); #1;
    i_s_ack = 1'b1;
    @(negedge i_clk);
    check("t5_ack_wins", 64'({o_m0_ack, o_m0_err, o_s_stb}), 64'h5);
    for (int m = 1; m <= 16; m++) begin
      @(posedge i_clk); #1;
      i_s_ack = 1'b0;
      @(negedge i_clk);
      check("t5_wdog_restart", 64'({o_m0_err, o_s_stb}), (m == 16) ? 64'h2 : 64'h1);
    end
    @(posedge i_clk); #1;
    m0_req(1'b0, 32'h600);

    // 6. reset during GNT0 with stb pending
    @(posedge i_clk); #1;
    m0_req(1'b1, 32'h700);
    @(posedge i_clk);
    @(negedge i_clk);
    check("t6_pre_grant", 64'(o_grant), 64'h1);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    m1_req(1'b1, 32'h800);
    @(posedge i_clk); #1;
    i_s_ack = 1'b1;
    @(negedge i_clk);
    check("t6_rst_abort", 64'({o_grant, o_s_cyc, o_s_stb}), 64'h0);
    check("t6_rst_no_resp", 64'({o_m0_ack, o_m0_err, o_m1_ack, o_m1_err}), 64'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_s_ack = 1'b0;
    wait_grant(g_s);
    check("t6_next_m0", 64'(g_s), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
